// File: rtl/uart_cmd_parser.sv
// Command interpreter between the UART RX/TX FIFOs and an 8-bit register bus.
// Accepts "Waadd<CR>" and "Raa<CR>" lines in ASCII hex and answers over TX.
module uart_cmd_parser #(
    parameter int RD_LATENCY = 1,
    parameter bit ECHO       = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_fifo_empty,
    input  logic [7:0] rx_fifo_data,
    output logic       rx_fifo_read_en,
    input  logic       tx_fifo_full,
    output logic [7:0] tx_fifo_data,
    output logic       tx_fifo_write_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       cmd_error
);

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_GAP,
        S_PARSE,
        S_EXEC_WR,
        S_EXEC_RD,
        S_WAIT_RD,
        S_RESP
    } state_t;

    state_t          state;
    logic [7:0]      rx_byte;
    logic [2:0]      char_idx;
    logic            err;
    logic            cmd_wr;
    logic [7:0]      addr_sh;
    logic [7:0]      wdata_sh;
    logic [3:0][7:0] resp_buf;
    logic [2:0]      resp_len;
    logic [2:0]      resp_ptr;
    logic [2:0]      lat_cnt;
    logic [4:0]      hv;
    logic [7:0]      up;

    // {valid, nibble}; letters are folded to upper case before the range test
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        logic [7:0] u;
        u = c & 8'hDF;
        if (c >= 8'h30 && c <= 8'h39)
            hex_val = {1'b1, c[3:0]};
        else if (u >= 8'h41 && u <= 8'h46)
            hex_val = {1'b1, u[3:0] + 4'd9};
        else
            hex_val = 5'd0;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            to_ascii = {4'h3, n};
        else
            to_ascii = 8'h37 + {4'h0, n};
    endfunction

    assign hv   = hex_val(rx_byte);
    assign up   = rx_byte & 8'hDF;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            rx_byte          <= 8'h00;
            char_idx         <= 3'd0;
            err              <= 1'b0;
            cmd_wr           <= 1'b0;
            addr_sh          <= 8'h00;
            wdata_sh         <= 8'h00;
            resp_buf         <= '0;
            resp_len         <= 3'd0;
            resp_ptr         <= 3'd0;
            lat_cnt          <= 3'd0;
            rx_fifo_read_en  <= 1'b0;
            tx_fifo_data     <= 8'h00;
            tx_fifo_write_en <= 1'b0;
            reg_addr         <= 8'h00;
            reg_wdata        <= 8'h00;
            reg_wr           <= 1'b0;
            reg_rd           <= 1'b0;
            cmd_error        <= 1'b0;
        end else begin
            rx_fifo_read_en  <= 1'b0;
            tx_fifo_write_en <= 1'b0;
            reg_wr           <= 1'b0;
            reg_rd           <= 1'b0;
            cmd_error        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_fifo_empty) begin
                        rx_fifo_read_en <= 1'b1;
                        state           <= S_POP;
                    end
                end
                S_POP: begin
                    rx_byte <= rx_fifo_data;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (!ECHO || rx_byte == LF) begin
                        state <= S_PARSE;
                    end else if (!tx_fifo_full && !tx_fifo_write_en) begin
                        tx_fifo_data     <= rx_byte;
                        tx_fifo_write_en <= 1'b1;
                        state            <= S_PARSE;
                    end
                end
                S_PARSE: begin
                    state <= S_IDLE;
                    if (rx_byte == CR) begin
                        char_idx <= 3'd0;
                        err      <= 1'b0;
                        if (char_idx == 3'd0) begin
                            state <= S_IDLE;
                        end else if (!err && cmd_wr && char_idx == 3'd5) begin
                            reg_addr  <= addr_sh;
                            reg_wdata <= wdata_sh;
                            reg_wr    <= 1'b1;
                            state     <= S_EXEC_WR;
                        end else if (!err && !cmd_wr && char_idx == 3'd3) begin
                            reg_addr <= addr_sh;
                            reg_rd   <= 1'b1;
                            state    <= S_EXEC_RD;
                        end else begin
                            cmd_error <= 1'b1;
                            resp_buf  <= {8'h00, LF, CR, 8'h3F};
                            resp_len  <= 3'd3;
                            resp_ptr  <= 3'd0;
                            state     <= S_RESP;
                        end
                    end else if (rx_byte != LF) begin
                        if (char_idx != 3'd6)
                            char_idx <= char_idx + 3'd1;
                        case (char_idx)
                            3'd0: begin
                                cmd_wr <= (up == 8'h57);
                                if (up != 8'h57 && up != 8'h52)
                                    err <= 1'b1;
                            end
                            3'd1, 3'd2: begin
                                addr_sh <= {addr_sh[3:0], hv[3:0]};
                                if (!hv[4])
                                    err <= 1'b1;
                            end
                            3'd3, 3'd4: begin
                                wdata_sh <= {wdata_sh[3:0], hv[3:0]};
                                if (!hv[4])
                                    err <= 1'b1;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_EXEC_WR: begin
                    resp_buf <= {8'h00, LF, CR, 8'h4B};
                    resp_len <= 3'd3;
                    resp_ptr <= 3'd0;
                    state    <= S_RESP;
                end
                S_EXEC_RD: begin
                    lat_cnt <= 3'd1;
                    state   <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (lat_cnt == 3'(RD_LATENCY)) begin
                        resp_buf <= {LF, CR, to_ascii(reg_rdata[3:0]),
                                     to_ascii(reg_rdata[7:4])};
                        resp_len <= 3'd4;
                        resp_ptr <= 3'd0;
                        state    <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    // push only every other cycle so full always reflects our last push
                    if (resp_ptr == resp_len) begin
                        state <= S_IDLE;
                    end else if (!tx_fifo_full && !tx_fifo_write_en) begin
                        tx_fifo_data     <= resp_buf[resp_ptr[1:0]];
                        tx_fifo_write_en <= 1'b1;
                        resp_ptr         <= resp_ptr + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: FIFO and register-bus models around
// one plain instance (RD_LATENCY=2) and one echoing instance (RD_LATENCY=1).
module tb_uart_cmd_parser;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_fifo_full = 1'b0;

    logic       rx_empty0 = 1'b1, rx_empty1 = 1'b1;
    logic [7:0] rx_data0 = 8'h00, rx_data1 = 8'h00;
    logic       rd_en0, rd_en1, we0, we1, wr0, wr1, rd0, rd1;
    logic       busy0, busy1, err0, err1;
    logic [7:0] txd0, txd1, addr0, addr1, wdata0, wdata1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] rdval0 = 8'h00, rdval1 = 8'h00;
    logic [1:0] rd_pipe0 = 2'b00;
    logic       rd_pipe1 = 1'b0;

    logic [7:0] rxq0 [$];
    logic [7:0] rxq1 [$];
    logic [7:0] txq0 [$];
    logic [7:0] txq1 [$];

    int wr_cnt0 = 0, rd_cnt0 = 0, er_cnt0 = 0, pop_cnt0 = 0;
    int rd_cnt1 = 0, er_cnt1 = 0, wr_cnt1 = 0;
    int bad_push = 0, adj_pop = 0, under = 0;
    logic [7:0] wr_a0 = 8'h00, wr_d0 = 8'h00, rd_a0 = 8'h00, rd_a1 = 8'h00;
    logic prev_rd0 = 1'b0, prev_rd1 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    uart_cmd_parser #(.RD_LATENCY(2), .ECHO(1'b0)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .rx_fifo_empty(rx_empty0), .rx_fifo_data(rx_data0),
        .rx_fifo_read_en(rd_en0), .tx_fifo_full(tx_fifo_full),
        .tx_fifo_data(txd0), .tx_fifo_write_en(we0),
        .reg_addr(addr0), .reg_wdata(wdata0), .reg_wr(wr0), .reg_rd(rd0),
        .reg_rdata(rdata0), .busy(busy0), .cmd_error(err0)
    );

    uart_cmd_parser #(.RD_LATENCY(1), .ECHO(1'b1)) u_echo (
        .clock(clock), .reset_n(reset_n),
        .rx_fifo_empty(rx_empty1), .rx_fifo_data(rx_data1),
        .rx_fifo_read_en(rd_en1), .tx_fifo_full(tx_fifo_full),
        .tx_fifo_data(txd1), .tx_fifo_write_en(we1),
        .reg_addr(addr1), .reg_wdata(wdata1), .reg_wr(wr1), .reg_rd(rd1),
        .reg_rdata(rdata1), .busy(busy1), .cmd_error(err1)
    );

    // read data is only valid exactly RD_LATENCY cycles after the strobe
    assign rdata0 = rd_pipe0[1] ? rdval0 : 8'hEE;
    assign rdata1 = rd_pipe1 ? rdval1 : 8'hEE;

    always @(posedge clock) begin
        rd_pipe0 <= {rd_pipe0[0], rd0};
        rd_pipe1 <= rd1;
        prev_rd0 <= rd_en0;
        prev_rd1 <= rd_en1;
        if (rd_en0) begin
            pop_cnt0 <= pop_cnt0 + 1;
            if (rxq0.size() > 0) void'(rxq0.pop_front());
            else under <= under + 1;
        end
        if (rd_en1) begin
            if (rxq1.size() > 0) void'(rxq1.pop_front());
            else under <= under + 1;
        end
        if ((rd_en0 && prev_rd0) || (rd_en1 && prev_rd1)) adj_pop <= adj_pop + 1;
        if ((we0 || we1) && tx_fifo_full) bad_push <= bad_push + 1;
        if (we0) txq0.push_back(txd0);
        if (we1) txq1.push_back(txd1);
        if (wr0) begin
            wr_cnt0 <= wr_cnt0 + 1;
            wr_a0   <= addr0;
            wr_d0   <= wdata0;
        end
        if (rd0) begin
            rd_cnt0 <= rd_cnt0 + 1;
            rd_a0   <= addr0;
        end
        if (wr1) wr_cnt1 <= wr_cnt1 + 1;
        if (rd1) begin
            rd_cnt1 <= rd_cnt1 + 1;
            rd_a1   <= addr1;
        end
        if (err0) er_cnt0 <= er_cnt0 + 1;
        if (err1) er_cnt1 <= er_cnt1 + 1;
    end

    always @(negedge clock) begin
        rx_empty0 <= (rxq0.size() == 0);
        rx_data0  <= (rxq0.size() != 0) ? rxq0[0] : 8'h00;
        rx_empty1 <= (rxq1.size() == 0);
        rx_data1  <= (rxq1.size() != 0) ? rxq1[0] : 8'h00;
    end

    task automatic send(input int inst, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (inst == 0) rxq0.push_back(s[i]);
            else rxq1.push_back(s[i]);
        end
    endtask

    task automatic wait_idle(input int inst, output bit ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clock);
            if (inst == 0)
                quiet = (rxq0.size() == 0 && !busy0 && !we0) ? quiet + 1 : 0;
            else
                quiet = (rxq1.size() == 0 && !busy1 && !we1) ? quiet + 1 : 0;
            if (quiet >= 3) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({rd_en0, txd0, we0, addr0, wdata0, wr0, rd0, busy0, err0} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_out0: got %h want 0",
                     {rd_en0, txd0, we0, addr0, wdata0, wr0, rd0, busy0, err0});
        end
        n_cmp++;
        if ({rd_en1, txd1, we1, addr1, wdata1, wr1, rd1, busy1, err1} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_out1: got %h want 0",
                     {rd_en1, txd1, we1, addr1, wdata1, wr1, rd1, busy1, err1});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({busy0, busy1, rd_en0, rd_en1} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b want 0000",
                     {busy0, busy1, rd_en0, rd_en1});
        end
    endtask

    task automatic test_write;
        logic [7:0] exp [$];
        int base, w, e;
        bit ok;
        exp  = '{8'h4B, 8'h0D, 8'h0A};
        base = txq0.size();
        w    = wr_cnt0;
        e    = er_cnt0;
        send(0, "W3A5C\r");
        wait_idle(0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wr_timeout: got busy want idle"); end
        n_cmp++;
        if ({wr_cnt0 - w, 24'(0)} !== {32'd1, 24'(0)} || {wr_a0, wr_d0} !== 16'h3A5C) begin
            n_bad++;
            $display("FAIL wr_bus: got n=%0d a=%h d=%h want n=1 a=3A d=5C",
                     wr_cnt0 - w, wr_a0, wr_d0);
        end
        n_cmp++;
        if (er_cnt0 - e !== 0) begin
            n_bad++;
            $display("FAIL wr_err: got %0d pulses want 0", er_cnt0 - e);
        end
        n_cmp++;
        if (txq0.size() - base !== exp.size()) begin
            n_bad++;
            $display("FAIL wr_txlen: got %0d want %0d", txq0.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size() && base + i < txq0.size(); i++) begin
            n_cmp++;
            if (txq0[base + i] !== exp[i]) begin
                n_bad++;
                $display("FAIL wr_tx%0d: got %h want %h", i, txq0[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_read;
        logic [7:0] exp [$];
        int base, r, w;
        bit ok;
        exp    = '{8'h42, 8'h37, 8'h0D, 8'h0A};
        base   = txq0.size();
        r      = rd_cnt0;
        w      = wr_cnt0;
        rdval0 = 8'hB7;
        send(0, "r3a\r");
        wait_idle(0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rd_timeout: got busy want idle"); end
        n_cmp++;
        if (rd_cnt0 - r !== 1 || rd_a0 !== 8'h3A || wr_cnt0 - w !== 0) begin
            n_bad++;
            $display("FAIL rd_bus: got rd=%0d a=%h wr=%0d want rd=1 a=3A wr=0",
                     rd_cnt0 - r, rd_a0, wr_cnt0 - w);
        end
        n_cmp++;
        if ({addr0, wdata0} !== 16'h3A5C) begin
            n_bad++;
            $display("FAIL rd_hold: got a=%h d=%h want a=3A d=5C", addr0, wdata0);
        end
        n_cmp++;
        if (txq0.size() - base !== exp.size()) begin
            n_bad++;
            $display("FAIL rd_txlen: got %0d want %0d", txq0.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size() && base + i < txq0.size(); i++) begin
            n_cmp++;
            if (txq0[base + i] !== exp[i]) begin
                n_bad++;
                $display("FAIL rd_tx%0d: got %h want %h", i, txq0[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic [7:0] exp [$];
        int base, r, w, e;
        bit ok;
        exp  = '{8'h3F, 8'h0D, 8'h0A, 8'h3F, 8'h0D, 8'h0A};
        base = txq0.size();
        r    = rd_cnt0;
        w    = wr_cnt0;
        e    = er_cnt0;
        send(0, "W3G00\rR12345\r");
        wait_idle(0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL er_timeout: got busy want idle"); end
        n_cmp++;
        if (rd_cnt0 - r !== 0 || wr_cnt0 - w !== 0 || er_cnt0 - e !== 2) begin
            n_bad++;
            $display("FAIL er_counts: got rd=%0d wr=%0d err=%0d want 0 0 2",
                     rd_cnt0 - r, wr_cnt0 - w, er_cnt0 - e);
        end
        n_cmp++;
        if (txq0.size() - base !== exp.size()) begin
            n_bad++;
            $display("FAIL er_txlen: got %0d want %0d", txq0.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size() && base + i < txq0.size(); i++) begin
            n_cmp++;
            if (txq0[base + i] !== exp[i]) begin
                n_bad++;
                $display("FAIL er_tx%0d: got %h want %h", i, txq0[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_full_stall;
        logic [7:0] exp [$];
        int base, r, p;
        bit ok, seen;
        exp          = '{8'h34, 8'h46, 8'h0D, 8'h0A};
        base         = txq0.size();
        r            = rd_cnt0;
        rdval0       = 8'h4F;
        tx_fifo_full = 1'b1;
        send(0, "R00\r\n");
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clock);
            seen = (rd_cnt0 != r);
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL fs_rd_timeout: got no reg_rd want 1"); end
        p = pop_cnt0;
        repeat (50) @(negedge clock);
        n_cmp++;
        if (txq0.size() - base !== 0 || pop_cnt0 !== p || busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL fs_stall: got tx=%0d pops=%0d busy=%b want 0 0 1",
                     txq0.size() - base, pop_cnt0 - p, busy0);
        end
        n_cmp++;
        if (rxq0.size() !== 1) begin
            n_bad++;
            $display("FAIL fs_rxheld: got %0d bytes queued want 1", rxq0.size());
        end
        tx_fifo_full = 1'b0;
        wait_idle(0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL fs_timeout: got busy want idle"); end
        n_cmp++;
        if (txq0.size() - base !== exp.size()) begin
            n_bad++;
            $display("FAIL fs_txlen: got %0d want %0d", txq0.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size() && base + i < txq0.size(); i++) begin
            n_cmp++;
            if (txq0[base + i] !== exp[i]) begin
                n_bad++;
                $display("FAIL fs_tx%0d: got %h want %h", i, txq0[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_echo;
        logic [7:0] exp [$];
        int base, r, e;
        bit ok;
        exp    = '{8'h0D, 8'h52, 8'h30, 8'h31, 8'h0D, 8'h39, 8'h41, 8'h0D, 8'h0A};
        base   = txq1.size();
        r      = rd_cnt1;
        e      = er_cnt1;
        rdval1 = 8'h9A;
        send(1, "\n\rR01\r");
        wait_idle(1, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ec_timeout: got busy want idle"); end
        n_cmp++;
        if (rd_cnt1 - r !== 1 || rd_a1 !== 8'h01 || er_cnt1 - e !== 0 || wr_cnt1 !== 0) begin
            n_bad++;
            $display("FAIL ec_bus: got rd=%0d a=%h err=%0d wr=%0d want 1 01 0 0",
                     rd_cnt1 - r, rd_a1, er_cnt1 - e, wr_cnt1);
        end
        n_cmp++;
        if (txq1.size() - base !== exp.size()) begin
            n_bad++;
            $display("FAIL ec_txlen: got %0d want %0d", txq1.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size() && base + i < txq1.size(); i++) begin
            n_cmp++;
            if (txq1[base + i] !== exp[i]) begin
                n_bad++;
                $display("FAIL ec_tx%0d: got %h want %h", i, txq1[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp [$];
        int base, r, w, e;
        bit ok, drained;
        exp    = '{8'h30, 8'h35, 8'h0D, 8'h0A};
        w      = wr_cnt0;
        send(0, "W12");
        drained = 1'b0;
        for (int c = 0; c < 100 && !drained; c++) begin
            @(negedge clock);
            drained = (rxq0.size() == 0);
        end
        n_cmp++;
        if (!drained) begin n_bad++; $display("FAIL rm_pop_timeout: got bytes left want 0"); end
        @(negedge clock);
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({rd_en0, txd0, we0, addr0, wdata0, wr0, rd0, busy0, err0} !== 35'd0) begin
                n_bad++;
                $display("FAIL rm_reset%0d: got %h want 0", c,
                         {rd_en0, txd0, we0, addr0, wdata0, wr0, rd0, busy0, err0});
            end
        end
        reset_n = 1'b1;
        @(negedge clock);
        base   = txq0.size();
        r      = rd_cnt0;
        e      = er_cnt0;
        rdval0 = 8'h05;
        send(0, "R12\r");
        wait_idle(0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rm_timeout: got busy want idle"); end
        n_cmp++;
        if (wr_cnt0 - w !== 0 || rd_cnt0 - r !== 1 || rd_a0 !== 8'h12 || er_cnt0 - e !== 0) begin
            n_bad++;
            $display("FAIL rm_bus: got wr=%0d rd=%0d a=%h err=%0d want 0 1 12 0",
                     wr_cnt0 - w, rd_cnt0 - r, rd_a0, er_cnt0 - e);
        end
        n_cmp++;
        if (txq0.size() - base !== exp.size()) begin
            n_bad++;
            $display("FAIL rm_txlen: got %0d want %0d", txq0.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size() && base + i < txq0.size(); i++) begin
            n_cmp++;
            if (txq0[base + i] !== exp[i]) begin
                n_bad++;
                $display("FAIL rm_tx%0d: got %h want %h", i, txq0[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_protocol;
        n_cmp++;
        if (adj_pop !== 0 || bad_push !== 0 || under !== 0) begin
            n_bad++;
            $display("FAIL protocol: got adj=%0d fullpush=%0d underflow=%0d want 0 0 0",
                     adj_pop, bad_push, under);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_errors;
        test_full_stall;
        test_echo;
        test_reset_mid;
        test_protocol;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
